// File: rtl/pipe_sub_64.sv
// Two-stage pipelined subtractor with borrow-in and a valid/ready handshake.
// Stage 1 subtracts the low halves and keeps the high operand halves.
// Stage 2 subtracts the high halves and forms diff, bout, zero and ovf.
module pipe_sub_64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned H = WIDTH / 2;

   // Stage 1 registers
   logic             r_s1_valid;
   logic [H-1:0]     r_s1_lo;
   logic             r_s1_bmid;
   logic [H-1:0]     r_s1_ahi;
   logic [H-1:0]     r_s1_bhi;

   // Stage 2 (output) registers
   logic             r_out_valid;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;
   logic             r_ovf;

   logic             w_s2_adv;
   logic             w_accept;
   logic [H:0]       w_lo;
   logic [H:0]       w_hi;
   logic [WIDTH-1:0] w_diff;
   logic             w_ovf;

   assign w_s2_adv = !r_out_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;
   assign w_accept = in_valid && in_ready;

   // Low-half subtraction; the extra top bit is the borrow into the high half
   assign w_lo = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, bin};

   // High-half subtraction using the captured operands and mid borrow
   assign w_hi   = {1'b0, r_s1_ahi} - {1'b0, r_s1_bhi} - {{H{1'b0}}, r_s1_bmid};
   assign w_diff = {w_hi[H-1:0], r_s1_lo};
   assign w_ovf  = (r_s1_ahi[H-1] != r_s1_bhi[H-1]) && (w_hi[H-1] != r_s1_ahi[H-1]);

   // Stage 1: refill whenever the slot is free or its entry moves on
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_lo    <= '0;
         r_s1_bmid  <= 1'b0;
         r_s1_ahi   <= '0;
         r_s1_bhi   <= '0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_accept) begin
            r_s1_lo    <= w_lo[H-1:0];
            r_s1_bmid  <= w_lo[H];
            r_s1_ahi   <= a[WIDTH-1:H];
            r_s1_bhi   <= b[WIDTH-1:H];
         end
      end
   end

   // Stage 2: load from stage 1 when the output is empty or being consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_diff <= w_diff;
            r_bout <= w_hi[H];
            r_zero <= (w_diff == '0);
            r_ovf  <= w_ovf;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign zero      = r_zero;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_sub_64.sv
// Self-checking bench for pipe_sub_64: directed corner cases, backpressure,
// mid-flight reset and a randomized stream scored against a plain-arithmetic model.
module tb_pipe_sub_64;

   localparam int unsigned W = 64;
   typedef logic [W+2:0] res_t;   // {bout, zero, ovf, diff}

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;
   logic         ovf;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   res_t        q[$];
   bit          hold;
   res_t        held;

   pipe_sub_64 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width unsigned subtraction and signed-range overflow test
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      logic [W:0]          u;
      logic signed [W+1:0] s;
      logic                o;
      u = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
      s = $signed({ma[W-1], ma[W-1], ma}) - $signed({mb[W-1], mb[W-1], mb}) - (W+2)'(mbin);
      o = !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
      return {u[W], (u[W-1:0] == '0), o, u[W-1:0]};
   endfunction

   function automatic res_t pack(input logic pb, input logic pz, input logic po, input logic [W-1:0] pd);
      return {pb, pz, po, pd};
   endfunction

   task automatic chk(input string name, input res_t act, input res_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted request is queued; every output is checked against the head
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", res_t'(out_valid), res_t'(1));
            chk("hold_data", pack(bout, zero, ovf, diff), held);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_output", pack(bout, zero, ovf, diff), '1);
            end else begin
               chk("result", pack(bout, zero, ovf, diff), q[0]);
               if (out_ready) void'(q.pop_front());
            end
         end
         hold = out_valid && !out_ready;
         held = pack(bout, zero, ovf, diff);
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, bin));
            chk("in_flight_le_2", res_t'(q.size() <= 2), res_t'(1));
         end
      end
   end

   // Present one request and hold it until accepted; returns just after the accept edge
   task automatic send(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
      bit ok;
      a = sa; b = sb; bin = sbin; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
      end
      if (!ok) chk("send_timeout", '0, '1);
   endtask

   task automatic drain();
      bit done;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         done = (q.size() == 0) && !out_valid;
      end
      if (!done) chk("drain_timeout", '0, '1);
   endtask

   // Single request into an empty pipe: checks two-stage latency and literal result
   task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic dbin, input res_t exp);
      chk({name, "_model"}, model(da, db, dbin), exp);
      out_ready = 1'b1;
      send(da, db, dbin);
      in_valid = 1'b0;
      chk({name, "_lat1_valid"}, res_t'(out_valid), res_t'(0));
      @(posedge clk); #1;
      chk({name, "_lat2_valid"}, res_t'(out_valid), res_t'(1));
      chk({name, "_lat2_data"}, pack(bout, zero, ovf, diff), exp);
      drain();
   endtask

   bit      rnd_done;
   logic [W-1:0] ra, rb;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      rnd_done = 1'b0;
      #12;
      chk("reset_in_ready", res_t'(in_ready), res_t'(1));
      chk("reset_outputs", pack(bout, zero, ovf, diff), '0);
      chk("reset_out_valid", res_t'(out_valid), res_t'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      directed("sub_5_3", 64'd5, 64'd3, 1'b0, pack(1'b0, 1'b0, 1'b0, 64'd2));
      directed("zero_borrow", 64'd0, 64'd0, 1'b1, pack(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF));
      directed("min_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
               pack(1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF));
      directed("mid_borrow", 64'h0000_0001_0000_0000, 64'd1, 1'b0,
               pack(1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF));
      directed("equal_zero", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
               pack(1'b0, 1'b1, 1'b0, 64'd0));

      // Backpressure: two accepts fill the pipe, then in_ready drops while stalled
      out_ready = 1'b0;
      send(64'd100, 64'd1, 1'b0);
      send(64'd200, 64'd2, 1'b0);
      a = 64'd300; b = 64'd3; bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", res_t'(in_ready), res_t'(0));
         chk("stall_out_valid", res_t'(out_valid), res_t'(1));
         chk("stall_head", pack(bout, zero, ovf, diff), pack(1'b0, 1'b0, 1'b0, 64'd99));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(64'd300, 64'd3, 1'b0);
      send(64'd400, 64'd4, 1'b1);
      drain();

      // Reset with two requests in flight
      out_ready = 1'b0;
      send(64'd7, 64'd1, 1'b0);
      send(64'd8, 64'd1, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", res_t'(out_valid), res_t'(0));
      chk("midrst_in_ready", res_t'(in_ready), res_t'(1));
      chk("midrst_outputs", pack(bout, zero, ovf, diff), '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("postrst_idle", res_t'(out_valid), res_t'(0));
      directed("postrst_first", 64'd50, 64'd8, 1'b1, pack(1'b0, 1'b0, 1'b0, 64'd41));

      // Randomized stream with random backpressure
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               case ($urandom_range(0, 3))
                  0: begin ra = {$urandom, $urandom}; rb = ra; end
                  1: begin
                     ra = {$urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF, $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0};
                     rb = {$urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF, $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0};
                  end
                  default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
               endcase
               send(ra, rb, 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk); #1;
               end
            end
            in_valid = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 9) < 7);
               @(posedge clk); #1;
            end
         end
      join
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_sub_64.md
PIPE_SUB_64 -- requirements
Module: pipe_sub_64

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width; even, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request operands are valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port diff  output  WIDTH  difference.
REQ-012 SHALL have port bout  output  1  unsigned borrow-out.
REQ-013 SHALL have port zero  output  1  diff equals 0.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL compute {bout,diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1), so bout=1 exactly when a < b+bin (unsigned).
REQ-016 SHALL set ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), independent of bin semantics beyond its effect on diff.
REQ-017 SHALL set zero = (diff == 0), regardless of bout.
REQ-018 SHALL split into two registered stages: S1 computes the low WIDTH/2 bits and the mid borrow, and captures the high operand halves; S2 computes the high half, bout, ovf and zero.
REQ-019 SHALL accept a request on a cycle with in_valid && in_ready; a transfer SHALL occur on out_valid && out_ready.
REQ-020 SHALL give a latency of 2 cycles: a request accepted at edge N with no backpressure presents out_valid at edge N+2.
REQ-021 SHALL sustain throughput of one result per cycle while out_ready stays high.
REQ-022 SHALL drive in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready; in_ready SHALL be combinational on out_ready, with no dependency on in_valid.
REQ-023 SHALL advance S1 into S2 when s1_valid && s2_adv, and clear out_valid on a transfer with no S1 entry advancing.
REQ-024 SHALL hold diff, bout, zero and ovf stable while out_valid && !out_ready.
REQ-025 SHALL never drop, duplicate or reorder requests; at most 2 requests in flight.
REQ-026 SHALL accept simultaneous accept, advance and transfer in the same cycle without a bubble.
REQ-027 SHALL keep data registers unchanged when their valid is low; outputs other than out_valid are don't-care while out_valid=0.

Reset
REQ-028 SHALL, on rst_n low, immediately clear s1_valid and out_valid, and drive diff=0, bout=0, zero=0, ovf=0.
REQ-029 SHALL drive in_ready=1 during and after reset.
REQ-030 SHALL discard all in-flight requests on reset mid-operation; the first request after rst_n rises SHALL be the first result produced.

Verification
REQ-031 SHALL be tested with a=5, b=3, bin=0 and out_ready=1 -> after 2 cycles diff=2, bout=0, zero=0, ovf=0.
REQ-032 SHALL be tested with a=0, b=0, bin=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, bout=1, zero=0, ovf=0.
REQ-033 SHALL be tested with a=64'h8000_0000_0000_0000, b=1, bin=0 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
REQ-034 SHALL be tested with a=64'h0000_0001_0000_0000, b=1, bin=0 -> diff=64'h0000_0000_FFFF_FFFF, verifying borrow propagation across the halves.
REQ-035 SHALL be tested by streaming 4 back-to-back requests while out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, out_valid and diff stay stable, and all 4 results emerge in order once out_ready=1.
REQ-036 SHALL be tested by asserting rst_n=0 with 2 requests in flight -> out_valid=0 at once, in_ready=1, and no stale result after reset.
REQ-037 SHALL be tested with 1000 random {a,b,bin} and random out_ready -> each {bout,diff} equals the reference model a-b-bin, and ovf and zero match the model.
